// File: rtl/sipo_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : sipo_bit_counter
// Description : Mod-WIDTH bit counter for the SIPO shift register. Counts
//               shifts within the current word and raises a registered
//               terminal-count pulse in the cycle after the last bit of a
//               word has been taken.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_bit_counter #(
    parameter int WIDTH = 4,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tc;
    logic          w_at_last;

    // At WIDTH=1 c_last is 0, so the counter never leaves 0 and tc fires every shift.
    assign w_at_last = (r_cnt == c_last);

    // Advance the in-word position and flag the word completed by this shift.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_tc  <= 1'b0;
        end else begin
            r_tc  <= w_at_last;
            r_cnt <= w_at_last ? '0 : r_cnt + CW'(1);
        end
    end

    assign cnt = r_cnt;
    assign tc  = r_tc;

endmodule
`default_nettype wire

// File: rtl/sipo_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : sipo_shift_register
// Description : Serial-in, parallel-out shift register. Takes one bit per
//               clock, presents the last WIDTH bits on pout and pulses pvalid
//               once per completed WIDTH-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
module sipo_shift_register #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    output logic [WIDTH-1:0] pout,
    output logic             pvalid,
    output logic [CW-1:0]    bit_cnt
);

    logic [WIDTH-1:0] r_pout;
    logic [WIDTH-1:0] w_pout_next;

    // Next-word shaping; the slices only exist when WIDTH > 1.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_pout_next = sin;
        end else if (MSB_FIRST) begin : g_msb_first
            assign w_pout_next = {r_pout[WIDTH-2:0], sin};
        end else begin : g_lsb_first
            assign w_pout_next = {sin, r_pout[WIDTH-1:1]};
        end
    endgenerate

    // Shift one serial bit into the word on every clock out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pout <= '0;
        end else begin
            r_pout <= w_pout_next;
        end
    end

    sipo_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clk (clk),
        .rst (rst),
        .cnt (bit_cnt),
        .tc  (pvalid)
    );

    assign pout = r_pout;

endmodule
`default_nettype wire

// File: tb/tb_sipo_shift_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_sipo_shift_register
// Description : Self-checking bench for sipo_shift_register. Four instances
//               (4-bit MSB-first, 4-bit LSB-first, 1-bit, 8-bit) share one
//               serial stream and reset; each is compared against a model
//               built from the history of bits received since reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sipo_shift_register;

    logic clk = 1'b0;
    logic rst;
    logic sin;

    always #5 clk = ~clk;

    logic [3:0] pout_a;  logic pvalid_a; logic [1:0] cnt_a;
    logic [3:0] pout_b;  logic pvalid_b; logic [1:0] cnt_b;
    logic [0:0] pout_c;  logic pvalid_c; logic [0:0] cnt_c;
    logic [7:0] pout_d;  logic pvalid_d; logic [2:0] cnt_d;

    sipo_shift_register #(.WIDTH(4), .MSB_FIRST(1'b1)) u_w4_msb (
        .clk(clk), .rst(rst), .sin(sin), .pout(pout_a), .pvalid(pvalid_a), .bit_cnt(cnt_a));
    sipo_shift_register #(.WIDTH(4), .MSB_FIRST(1'b0)) u_w4_lsb (
        .clk(clk), .rst(rst), .sin(sin), .pout(pout_b), .pvalid(pvalid_b), .bit_cnt(cnt_b));
    sipo_shift_register #(.WIDTH(1), .MSB_FIRST(1'b0)) u_w1 (
        .clk(clk), .rst(rst), .sin(sin), .pout(pout_c), .pvalid(pvalid_c), .bit_cnt(cnt_c));
    sipo_shift_register #(.WIDTH(8), .MSB_FIRST(1'b1)) u_w8 (
        .clk(clk), .rst(rst), .sin(sin), .pout(pout_d), .pvalid(pvalid_d), .bit_cnt(cnt_d));

    // Bits accepted since the last reset, oldest first.
    logic hist[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // The word holds the newest WIDTH bits: MSB-first puts the newest in bit 0,
    // LSB-first puts it in bit WIDTH-1. Slots not yet filled are 0.
    function automatic logic [63:0] exp_pout(input int w, input bit msb);
        logic [63:0] r;
        int k;
        r = '0;
        for (int i = 0; i < w; i++) begin
            k = hist.size() - 1 - i;
            if (k >= 0) begin
                if (msb) r[i] = hist[k];
                else     r[w-1-i] = hist[k];
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] exp_cnt(input int w);
        return 64'(hist.size() % w);
    endfunction

    function automatic logic [63:0] exp_valid(input int w);
        return 64'((hist.size() > 0) && (hist.size() % w == 0));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h (bits since reset=%0d)",
                   tag, obs, exp, hist.size());
        end
    endtask

    task automatic check_all();
        chk("w4msb.pout",   64'(pout_a),   exp_pout(4, 1'b1));
        chk("w4msb.cnt",    64'(cnt_a),    exp_cnt(4));
        chk("w4msb.pvalid", 64'(pvalid_a), exp_valid(4));
        chk("w4lsb.pout",   64'(pout_b),   exp_pout(4, 1'b0));
        chk("w4lsb.cnt",    64'(cnt_b),    exp_cnt(4));
        chk("w4lsb.pvalid", 64'(pvalid_b), exp_valid(4));
        chk("w1.pout",      64'(pout_c),   exp_pout(1, 1'b0));
        chk("w1.cnt",       64'(cnt_c),    exp_cnt(1));
        chk("w1.pvalid",    64'(pvalid_c), exp_valid(1));
        chk("w8.pout",      64'(pout_d),   exp_pout(8, 1'b1));
        chk("w8.cnt",       64'(cnt_d),    exp_cnt(8));
        chk("w8.pvalid",    64'(pvalid_d), exp_valid(8));
    endtask

    // One clock with the given serial bit; outputs checked 1 time unit after the edge.
    task automatic step(input logic b);
        sin = b;
        @(posedge clk);
        if (rst) hist.push_back(b);
        #1;
        check_all();
    endtask

    // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        hist.delete();
        #1;
        check_all();
        @(negedge clk);
        check_all();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        sin = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;

        // Basic load: 1,0,1,0
        step(1'b1); step(1'b0); step(1'b1); step(1'b0);
        chk("basic.w4msb.pout", 64'(pout_a), 64'hA);
        chk("basic.w4lsb.pout", 64'(pout_b), 64'h5);

        // Continuous ones across two words
        repeat (8) step(1'b1);
        chk("stream.w4msb.pout", 64'(pout_a), 64'hF);

        // Reset mid-word after two bits, then reload 1,1,0,0
        step(1'b1); step(1'b1);
        do_reset();
        step(1'b1); step(1'b1); step(1'b0); step(1'b0);
        chk("reload.w4msb.pout",   64'(pout_a),   64'hC);
        chk("reload.w4msb.pvalid", 64'(pvalid_a), 64'h1);

        // Random stream with occasional mid-word resets
        for (int i = 0; i < 120; i++) begin
            step(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 23) == 0) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
